// File: rtl/ring_cadence_ctrl.sv
// ring_cadence_ctrl: ringing sequencer for incoming calls.
// Drives an external 4-bit countdown timer (load strobe, load value, tick
// strobe), alternates ring-on/ring-off intervals, counts rings and reports
// answered / cancelled / no-answer outcomes.
// Optional feature macro: MISSED_CALL_LATCH_EN (sticky missed_call flag).
module ring_cadence_ctrl #(
  parameter int unsigned TICK_DIV  = 27000000,
  parameter int unsigned RING_ON   = 2,
  parameter int unsigned RING_OFF  = 4,
  parameter int unsigned MAX_RINGS = 6
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       ring_req,
  input  logic       answered,
  input  logic       cancel,
  input  logic       timer_expired,
  output logic       start_timer,
  output logic [3:0] timer_value,
  output logic       timer_enable,
  output logic       ringing,
  output logic [3:0] ring_count,
  output logic       call_answered,
  output logic       no_answer,
  output logic       missed_call,
  input  logic       clear_missed
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ON,
    S_WAIT_ON,
    S_LOAD_OFF,
    S_WAIT_OFF,
    S_GIVE_UP,
    S_ANSWER
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      ring_count_q, ring_count_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic            abortable;

  // State, ring counter and tick divider registers
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q      <= S_IDLE;
      ring_count_q <= '0;
      tick_q       <= '0;
    end else begin
      state_q      <= state_d;
      ring_count_q <= ring_count_d;
      tick_q       <= tick_d;
    end
  end

  // Next-state logic: cancel beats answered beats timer expiry beats ring_req
  always_comb begin
    state_d      = state_q;
    ring_count_d = ring_count_q;
    abortable    = !(state_q inside {S_IDLE, S_GIVE_UP, S_ANSWER});

    // Every visit to LOAD_ON starts a ring-on period, however it is left.
    if (state_q == S_LOAD_ON && ring_count_q != 4'hF)
      ring_count_d = ring_count_q + 4'd1;

    if (abortable && cancel) begin
      state_d = S_IDLE;
    end else if (abortable && answered) begin
      state_d = S_ANSWER;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ring_req) begin
            state_d      = S_LOAD_ON;
            ring_count_d = '0;
          end
        end
        S_LOAD_ON:  state_d = S_WAIT_ON;
        S_WAIT_ON: begin
          if (timer_expired)
            state_d = (ring_count_q == 4'(MAX_RINGS)) ? S_GIVE_UP : S_LOAD_OFF;
        end
        S_LOAD_OFF: state_d = S_WAIT_OFF;
        S_WAIT_OFF: begin
          if (timer_expired)
            state_d = S_LOAD_ON;
        end
        S_GIVE_UP:  state_d = S_IDLE;
        S_ANSWER:   state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state; tick divider restarts on each load
  always_comb begin
    start_timer   = (state_q == S_LOAD_ON) || (state_q == S_LOAD_OFF);
    timer_value   = '0;
    if (state_q == S_LOAD_ON)  timer_value = 4'(RING_ON);
    if (state_q == S_LOAD_OFF) timer_value = 4'(RING_OFF);
    ringing       = (state_q == S_WAIT_ON);
    call_answered = (state_q == S_ANSWER);
    no_answer     = (state_q == S_GIVE_UP);
    ring_count    = ring_count_q;
    timer_enable  = (tick_q == CW'(TICK_DIV - 1));
    tick_d        = (start_timer || timer_enable) ? '0 : tick_q + CW'(1);
  end

`ifdef MISSED_CALL_LATCH_EN
  logic missed_q, missed_d;

  // Sticky missed-call flag; a new no-answer wins over a coincident clear
  always_comb begin
    missed_d = missed_q;
    if (no_answer)         missed_d = 1'b1;
    else if (clear_missed) missed_d = 1'b0;
  end

  // Missed-call flag register
  always_ff @(posedge clk) begin
    if (sys_reset) missed_q <= 1'b0;
    else           missed_q <= missed_d;
  end

  assign missed_call = missed_q;
`else
  logic unused_clear_missed;
  assign unused_clear_missed = clear_missed;
  assign missed_call = 1'b0;
`endif

endmodule

// File: tb/tb_ring_cadence_ctrl.sv
// Testbench for ring_cadence_ctrl: directed scenarios plus random stimulus,
// a behavioural countdown timer attached to the DUT, and a call-level
// reference model checked every cycle.
module tb_ring_cadence_ctrl;

  localparam int TD  = 4;
  localparam int RON = 2;
  localparam int ROFF = 3;
  localparam int MR  = 2;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b0, ring_req = 1'b0, answered = 1'b0, cancel = 1'b0;
  logic       clear_missed = 1'b0;
  logic       timer_expired;
  logic       start_timer, timer_enable, ringing, call_answered, no_answer, missed_call;
  logic [3:0] timer_value, ring_count;

  int n_checks = 0;
  int n_fail   = 0;

  ring_cadence_ctrl #(
    .TICK_DIV (TD),
    .RING_ON  (RON),
    .RING_OFF (ROFF),
    .MAX_RINGS(MR)
  ) dut (
    .clk          (clk),
    .sys_reset    (sys_reset),
    .ring_req     (ring_req),
    .answered     (answered),
    .cancel       (cancel),
    .timer_expired(timer_expired),
    .start_timer  (start_timer),
    .timer_value  (timer_value),
    .timer_enable (timer_enable),
    .ringing      (ringing),
    .ring_count   (ring_count),
    .call_answered(call_answered),
    .no_answer    (no_answer),
    .missed_call  (missed_call),
    .clear_missed (clear_missed)
  );

  always #5 clk = ~clk;

  // Countdown timer: load wins over decrement; one-cycle expiry pulse on reaching 0
  logic [3:0] tcount = 4'd0;
  logic       texp   = 1'b0;
  always @(posedge clk) begin
    if (start_timer) begin
      tcount <= timer_value;
      texp   <= 1'b0;
    end else if (timer_enable && tcount != 4'd0) begin
      tcount <= tcount - 4'd1;
      texp   <= (tcount == 4'd1);
    end else begin
      texp   <= 1'b0;
    end
  end
  assign timer_expired = texp;

  // Reference model: a call is either in progress (in an on/off half, possibly
  // in its load cycle) or not; outcome pulses last one cycle.
  bit m_valid = 0, m_call = 0, m_on = 0, m_load = 0, m_ans = 0, m_na = 0, m_missed = 0;
  int m_rings = 0;
  int m_k = 0;   // cycles since the last reset or timer load

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rr, input bit an, input bit ca, input bit cl,
                              input bit rs, input bit ex);
    bit was_pulse;
    bit loaded;
    if (rs) begin
      m_valid = 1; m_call = 0; m_on = 0; m_load = 0;
      m_ans = 0; m_na = 0; m_rings = 0; m_missed = 0; m_k = 1;
      return;
    end
    if (!m_valid) return;
    loaded = m_call && m_load;
    m_k = loaded ? 1 : m_k + 1;
`ifdef MISSED_CALL_LATCH_EN
    if (m_na)     m_missed = 1;
    else if (cl)  m_missed = 0;
`endif
    was_pulse = m_ans || m_na;
    m_ans = 0;
    m_na  = 0;
    if (m_call) begin
      if (m_load && m_on && m_rings < 15) m_rings++;
      if (ca) m_call = 0;
      else if (an) begin m_call = 0; m_ans = 1; end
      else if (m_load) m_load = 0;
      else if (ex) begin
        if (m_on && m_rings == MR) begin m_call = 0; m_na = 1; end
        else begin m_on = !m_on; m_load = 1; end
      end
    end else if (!was_pulse && rr) begin
      m_call = 1; m_on = 1; m_load = 1; m_rings = 0;
    end
  endtask

  task automatic check_outputs();
    bit st;
    st = m_call && m_load;
    check_eq("start_timer",   32'(start_timer),   32'(st));
    check_eq("timer_value",   32'(timer_value),   st ? (m_on ? RON : ROFF) : 0);
    check_eq("ringing",       32'(ringing),       32'(m_call && m_on && !m_load));
    check_eq("call_answered", 32'(call_answered), 32'(m_ans));
    check_eq("no_answer",     32'(no_answer),     32'(m_na));
    check_eq("ring_count",    32'(ring_count),    m_rings);
    check_eq("timer_enable",  32'(timer_enable),  32'((m_k % TD) == 0));
    check_eq("missed_call",   32'(missed_call),   32'(m_missed));
  endtask

  // One clock cycle: drive inputs (we sit at a negedge), advance, check at next negedge
  task automatic cyc(input bit rr, input bit an, input bit ca, input bit cl, input bit rs);
    bit ex;
    ring_req = rr; answered = an; cancel = ca; clear_missed = cl; sys_reset = rs;
    ex = timer_expired;
    @(posedge clk);
    model_update(rr, an, ca, cl, rs, ex);
    @(negedge clk);
    if (m_valid) check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    idle(5);

    // Reset in the middle of a ring-on interval
    cyc(1, 0, 0, 0, 0);
    for (int g = 0; g < 50 && !(m_call && m_on && !m_load); g++) idle(1);
    check_eq("reach_wait_on", 32'(ringing), 1);
    idle(3);
    cyc(0, 0, 0, 0, 1);
    idle(12);

    // Full no-answer sequence
    cyc(1, 0, 0, 0, 0);
    for (int g = 0; g < 200 && !m_na; g++) idle(1);
    check_eq("no_answer_seen", 32'(no_answer), 1);
    idle(3);

    // Missed-call flag persists through a new call, then cleared
    cyc(1, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0);
    idle(3);

    // Answer during the ring-off interval
    cyc(1, 0, 0, 0, 0);
    for (int g = 0; g < 100 && !(m_call && !m_on && !m_load); g++) idle(1);
    check_eq("reach_wait_off", 32'(m_call && !m_on && !m_load && ringing == 1'b0), 1);
    idle(2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(25);

    // cancel and answered together while ringing
    cyc(1, 0, 0, 0, 0);
    for (int g = 0; g < 50 && !(m_call && m_on && !m_load); g++) idle(1);
    idle(2);
    cyc(0, 1, 1, 0, 0);
    idle(20);

    // ring_req during ring-off is ignored; answered coincides with final expiry
    cyc(1, 0, 0, 0, 0);
    for (int g = 0; g < 100 && !(m_call && !m_on && !m_load); g++) idle(1);
    cyc(1, 0, 0, 0, 0);
    for (int g = 0; g < 200 && !(m_call && m_on && !m_load && m_rings == MR && timer_expired); g++)
      idle(1);
    check_eq("final_expiry_seen", 32'(timer_expired && ringing), 1);
    cyc(0, 1, 0, 0, 0);
    idle(20);

    // Random traffic
    for (int i = 0; i < 5000; i++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
          $urandom_range(0, 119) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 999) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
